ucy_cnt: RTL and testbench

Parametrised synchronous counter for the TTL model library: the generalised successor of the fixed-function gate and flip-flop chips, covering the 74160/74161/74163/74193 family in one block. It provides binary or modulo-N counting, synchronous clear and parallel load, and optional up/down operation. A ripple-carry output lets instances cascade into wider counters, for example address, timing and refresh counters in the machine model.

---
 rtl/ucy_pkg.sv | 11 +
 rtl/ucy_cnt_next.sv | 46 ++++
 rtl/ucy_cnt.sv | 81 ++++++++
 tb/tb_ucy_cnt.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ucy_pkg.sv
// Shared types and limits for the ucy_cnt universal counter.
package ucy_pkg;

    typedef enum logic {
        UCY_DN = 1'b0,
        UCY_UP = 1'b1
    } ucy_dir_t;

    localparam int unsigned UCY_CNT_MAX_WIDTH = 16;

endpackage

// File: rtl/ucy_cnt_next.sv
// Combinational successor and terminal-count logic for ucy_cnt, including
// out-of-range recovery. Down counting is compiled in only with UCY_CNT_UPDOWN_EN.
module ucy_cnt_next
    import ucy_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
`ifdef UCY_CNT_UPDOWN_EN
    input  ucy_dir_t         dir,
`endif
    output logic [WIDTH-1:0] q_next,
    output logic             tc
);

    // One extra bit so MODULUS == 2**WIDTH is representable in compares.
    localparam int unsigned XW = WIDTH + 1;
    localparam logic [WIDTH:0] MOD_X = XW'(MODULUS);
    localparam logic [WIDTH:0] MAX_X = XW'(MODULUS - 1);

    logic [WIDTH:0] q_x;
    logic [WIDTH:0] nxt_x;

    assign q_x = {1'b0, q};

    always_comb begin
        nxt_x = '0;
        tc    = 1'b0;
`ifdef UCY_CNT_UPDOWN_EN
        if (dir == UCY_DN) begin
            tc    = (q_x == '0);
            nxt_x = ((q_x == '0) || (q_x >= MOD_X)) ? MAX_X : (q_x - XW'(1));
        end else begin
            tc    = (q_x == MAX_X);
            nxt_x = (q_x >= MAX_X) ? '0 : (q_x + XW'(1));
        end
`else
        tc    = (q_x == MAX_X);
        nxt_x = (q_x >= MAX_X) ? '0 : (q_x + XW'(1));
`endif
    end

    assign q_next = WIDTH'(nxt_x);

endmodule

// File: rtl/ucy_cnt.sv
// Universal synchronous counter (74160/161/163/193 family): clear, load, P/T enables,
// ripple carry. Define UCY_CNT_UPDOWN_EN to add the up port and down counting.
module ucy_cnt
    import ucy_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 16,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             enp,
    input  logic             ent,
`ifdef UCY_CNT_UPDOWN_EN
    input  logic             up,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             rco
);

    if ((WIDTH < 1) || (WIDTH > UCY_CNT_MAX_WIDTH)) begin : g_bad_width
        $error("ucy_cnt: WIDTH must be 1..%0d", UCY_CNT_MAX_WIDTH);
    end
    if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
        $error("ucy_cnt: MODULUS must be 2..2**WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset
        $error("ucy_cnt: RESET_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_succ;
    logic             tc_c;

`ifdef UCY_CNT_UPDOWN_EN
    ucy_dir_t dir_c;
    assign dir_c = ucy_dir_t'(up);
`endif

    ucy_cnt_next #(
        .WIDTH  (WIDTH),
        .MODULUS(MODULUS)
    ) u_next (
        .q     (q_q),
`ifdef UCY_CNT_UPDOWN_EN
        .dir   (dir_c),
`endif
        .q_next(q_succ),
        .tc    (tc_c)
    );

    // Priority below reset: clear, load, count, hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end else if (enp && ent) begin
            q_d = q_succ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= WIDTH'(RESET_VAL);
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign tc  = tc_c;
    assign rco = tc_c & ent;

endmodule

// File: tb/tb_ucy_cnt.sv
// Self-checking bench for ucy_cnt: two cascaded decade stages plus a binary counter,
// checked every cycle against an integer model and at directed points against literals.
module tb_ucy_cnt;

    logic       clk = 1'b0;
    logic       rst, clr, load, enp, ent0, entb;
    logic [3:0] d;
    logic       up_s;
    logic [3:0] q0, q1, qb;
    logic       tc0, tc1, tcb, rco0, rco1, rcob;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int m0 = 0, m1 = 0, mb = 0;

    always #5 clk = ~clk;

    ucy_cnt #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d), .enp(enp), .ent(ent0),
`ifdef UCY_CNT_UPDOWN_EN
        .up(up_s),
`endif
        .q(q0), .tc(tc0), .rco(rco0));

    ucy_cnt #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d), .enp(enp), .ent(rco0),
`ifdef UCY_CNT_UPDOWN_EN
        .up(up_s),
`endif
        .q(q1), .tc(tc1), .rco(rco1));

    ucy_cnt #(.WIDTH(4), .MODULUS(16), .RESET_VAL(3)) dutb (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d), .enp(enp), .ent(entb),
`ifdef UCY_CNT_UPDOWN_EN
        .up(up_s),
`endif
        .q(qb), .tc(tcb), .rco(rcob));

    function automatic bit is_tc(int v, int mod, bit dir_up);
        return dir_up ? (v == mod - 1) : (v == 0);
    endfunction

    function automatic int succ(int v, int mod, bit dir_up);
        if (dir_up) return (v + 1 >= mod) ? 0 : v + 1;
        return (v == 0 || v >= mod) ? mod - 1 : v - 1;
    endfunction

    function automatic int model_next(int v, int mod, int rv, bit en, bit dir_up);
        if (rst)  return rv;
        if (clr)  return 0;
        if (load) return int'(d);
        if (en)   return succ(v, mod, dir_up);
        return v;
    endfunction

    // Reference model advances on every rising edge from the sampled inputs.
    always @(posedge clk) begin
        bit e1;
        e1 = is_tc(m0, 10, up_s) && ent0;
        m0 = model_next(m0, 10, 0, enp && ent0, up_s);
        m1 = model_next(m1, 10, 0, enp && e1, up_s);
        mb = model_next(mb, 16, 3, enp && entb, up_s);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit r0;
            r0 = is_tc(m0, 10, up_s) && ent0;
            chk("m_q0", int'(q0), m0);
            chk("m_tc0", int'(tc0), int'(is_tc(m0, 10, up_s)));
            chk("m_rco0", int'(rco0), int'(r0));
            chk("m_q1", int'(q1), m1);
            chk("m_rco1", int'(rco1), int'(is_tc(m1, 10, up_s) && r0));
            chk("m_qb", int'(qb), mb);
            chk("m_tcb", int'(tcb), int'(is_tc(mb, 16, up_s)));
            chk("m_rcob", int'(rcob), int'(is_tc(mb, 16, up_s) && entb));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int dec_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        rst = 1'b1; clr = 1'b0; load = 1'b0; d = 4'd0;
        enp = 1'b0; ent0 = 1'b0; entb = 1'b0; up_s = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_q0", int'(q0), 0);
        chk("rst_qb", int'(qb), 3);
        chk("rst_tc0", int'(tc0), 0);

        // Decade count from reset
        enp = 1'b1; ent0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("dec_q", int'(q0), dec_exp[i]);
            chk("dec_rco", int'(rco0), (dec_exp[i] == 9) ? 1 : 0);
        end

        // Priority: rst > clr > load > count
        rst = 1'b1; clr = 1'b1; load = 1'b1; d = 4'd5; entb = 1'b1;
        step();
        chk("pri_rst_q0", int'(q0), 0);
        chk("pri_rst_qb", int'(qb), 3);
        rst = 1'b0;
        step();
        chk("pri_clr_qb", int'(qb), 0);
        clr = 1'b0;
        step();
        chk("pri_load_q0", int'(q0), 5);
        chk("pri_load_qb", int'(qb), 5);
        load = 1'b0; entb = 1'b0;

        // Out-of-range load and recovery
        enp = 1'b0; load = 1'b1; d = 4'd13;
        step();
        load = 1'b0;
        chk("oor_q", int'(q0), 13);
        chk("oor_tc", int'(tc0), 0);
        enp = 1'b1;
`ifdef UCY_CNT_UPDOWN_EN
        up_s = 1'b0;
        step();
        chk("oor_dn_q", int'(q0), 9);
        up_s = 1'b1;
`else
        step();
        chk("oor_up_q", int'(q0), 0);
`endif

        // Two-stage decade cascade
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            step();
            chk("casc_val", int'(q1) * 10 + int'(q0), i % 100);
            chk("casc_rco", int'(rco1), (i == 99) ? 1 : 0);
        end

        // Enable gating at terminal count
        load = 1'b1; d = 4'd9;
        step();
        load = 1'b0; ent0 = 1'b0; enp = 1'b1;
        #1;
        chk("gate_t0_rco", int'(rco0), 0);
        step();
        chk("gate_t0_q", int'(q0), 9);
        chk("gate_t0_tc", int'(tc0), 1);
        ent0 = 1'b1; enp = 1'b0;
        step();
        chk("gate_p0_q", int'(q0), 9);
        chk("gate_p0_rco", int'(rco0), 1);

        // Binary wrap through 2**WIDTH
        load = 1'b1; d = 4'd14; entb = 1'b1;
        step();
        load = 1'b0; enp = 1'b1;
        step();
        chk("bin_q15", int'(qb), 15);
        chk("bin_tc15", int'(tcb), 1);
        step();
        chk("bin_wrap", int'(qb), 0);

`ifdef UCY_CNT_UPDOWN_EN
        // Down count and direction toggle
        load = 1'b1; d = 4'd1; enp = 1'b0;
        step();
        load = 1'b0; enp = 1'b1; up_s = 1'b0;
        step();
        chk("dn_q0", int'(qb), 0);
        chk("dn_tc0", int'(tcb), 1);
        step();
        chk("dn_q15", int'(qb), 15);
        chk("dn_tc15", int'(tcb), 0);
        step();
        chk("dn_q14", int'(qb), 14);
        load = 1'b1; d = 4'd15; enp = 1'b0;
        step();
        load = 1'b0;
        chk("tog_tc_dn", int'(tcb), 0);
        up_s = 1'b1;
        #1;
        chk("tog_tc_up", int'(tcb), 1);
        step();
`endif

        step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
